// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment monitor.
//   - segment patterns, ordered {a,b,c,d,e,f,g}, for the five legal digits
//   - report codes, including the invalid-pattern code
//   - report FSM state type
package seg_pkg;

  localparam logic [6:0] PAT_0 = 7'b1111110;
  localparam logic [6:0] PAT_1 = 7'b0110000;
  localparam logic [6:0] PAT_2 = 7'b1101101;
  localparam logic [6:0] PAT_3 = 7'b1111001;
  localparam logic [6:0] PAT_E = 7'b1001111;

  localparam logic [2:0] CODE_0   = 3'b000;
  localparam logic [2:0] CODE_1   = 3'b001;
  localparam logic [2:0] CODE_2   = 3'b010;
  localparam logic [2:0] CODE_3   = 3'b011;
  localparam logic [2:0] CODE_E   = 3'b100;
  localparam logic [2:0] CODE_INV = 3'b111;

  typedef enum logic {WAIT, HOLD} state_t;

endpackage

// File: rtl/seven_segment_monitor_if.sv
// seven_segment_monitor_if: report handshake between the monitor and its
// consumer.
//   out_valid  report available (producer -> consumer)
//   out_ready  consumer accepts the current report
//   code       decoded value
//   code_err   reported pattern is not in the decode table
// Modports: master = monitor side, slave = consumer side.
interface seven_segment_monitor_if;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] code;
  logic       code_err;

  modport master (output out_valid, output code, output code_err, input out_ready);
  modport slave  (input out_valid, input code, input code_err, output out_ready);
endinterface

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational lookup of a 7-bit segment pattern.
//   pattern   {a,b,c,d,e,f,g}
//   code      decoded value, CODE_INV for anything not in the table
//   code_err  1 when the pattern is not in the table
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [2:0] code,
  output logic       code_err
);

  always_comb begin
    code     = CODE_INV;
    code_err = 1'b1;
    case (pattern)
      PAT_0: begin code = CODE_0; code_err = 1'b0; end
      PAT_1: begin code = CODE_1; code_err = 1'b0; end
      PAT_2: begin code = CODE_2; code_err = 1'b0; end
      PAT_3: begin code = CODE_3; code_err = 1'b0; end
      PAT_E: begin code = CODE_E; code_err = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/seven_segment_monitor.sv
// seven_segment_monitor: samples seven segment lines, qualifies a pattern once
// it has been stable for STABLE_CYCLES samples, and reports each newly
// qualified pattern over a valid/ready handshake.
//   clk              rising-edge clock
//   reset_a          asynchronous active-high reset
//   seg_a..seg_g     segment lines, synchronous to clk
//   rpt              report handshake (out_valid/out_ready/code/code_err)
//   overrun          sticky: a qualified pattern arrived while a report was held
//   err_cnt          saturating count of captured invalid reports
// Build option: define SEG_ERR_CNT_EN to compile the err_cnt counter;
// otherwise err_cnt is tied to zero.
module seven_segment_monitor
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset_a,
  input  logic                    seg_a,
  input  logic                    seg_b,
  input  logic                    seg_c,
  input  logic                    seg_d,
  input  logic                    seg_e,
  input  logic                    seg_f,
  input  logic                    seg_g,
  seven_segment_monitor_if.master rpt,
  output logic                    overrun,
  output logic [7:0]              err_cnt
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [6:0]       seg_q, seg_prev, last_rep;
  logic [CNT_W-1:0] cnt;
  logic             primed, reach, first_pend, qual, chg;
  logic [2:0]       dec_code, code_r;
  logic             dec_err, err_r;
  state_t           state, state_nx;
  logic             capture, drop;

  // seg_prev is the pattern the counter describes: after an edge, cnt is the
  // number of consecutive samples equal to seg_prev.
  assign chg = (seg_q != seg_prev);

  // primed masks the first edge after reset, where seg_q still holds the
  // reset value rather than a real sample.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      seg_q    <= '0;
      seg_prev <= '0;
      cnt      <= '0;
      primed   <= 1'b0;
      reach    <= 1'b0;
    end else begin
      seg_q    <= {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
      seg_prev <= seg_q;
      primed   <= 1'b1;
      reach    <= 1'b0;
      if (primed) begin
        if (chg || cnt == '0) begin
          cnt   <= ONE;
          reach <= (STABLE == ONE);
        end else if (cnt < STABLE) begin
          cnt   <= cnt + ONE;
          reach <= (cnt + ONE == STABLE);
        end
      end
    end
  end

  // reach is one-shot per run, so a saturated counter never requalifies.
  assign qual = reach && (first_pend || seg_prev != last_rep);

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      last_rep   <= '0;
      first_pend <= 1'b1;
    end else if (qual) begin
      last_rep   <= seg_prev;
      first_pend <= 1'b0;
    end
  end

  seg_pattern_decode u_dec (
    .pattern  (seg_prev),
    .code     (dec_code),
    .code_err (dec_err)
  );

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    drop     = 1'b0;
    case (state)
      WAIT: if (qual) begin
        capture  = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        if (rpt.out_ready) begin
          // accept and a new qualification together: replace, stay valid
          if (qual) capture  = 1'b1;
          else      state_nx = WAIT;
        end else if (qual) begin
          drop = 1'b1;
        end
      end
      default: state_nx = WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state   <= WAIT;
      code_r  <= '0;
      err_r   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (capture) begin
        code_r <= dec_code;
        err_r  <= dec_err;
      end
      if (drop) overrun <= 1'b1;
    end
  end

  assign rpt.out_valid = (state == HOLD);
  assign rpt.code      = code_r;
  assign rpt.code_err  = err_r;

`ifdef SEG_ERR_CNT_EN
  logic [7:0] err_q;
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a)                                 err_q <= '0;
    else if (capture && dec_err && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end
  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_seven_segment_monitor.sv
// tb_seven_segment_monitor: scoreboard bench. DUT a uses STABLE_CYCLES=4,
// DUT b uses STABLE_CYCLES=1. Expected reports are queued as stimulus is
// driven and popped on every accepted report.
module tb_seven_segment_monitor;
  import seg_pkg::*;

  logic       clk = 1'b0;
  logic       rsta, rstb;
  logic [6:0] sa, sb;
  logic       ova, ovb;
  logic [7:0] eca, ecb;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] qa[$];
  logic [3:0] qb[$];

`ifdef SEG_ERR_CNT_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  seven_segment_monitor_if ia ();
  seven_segment_monitor_if ib ();

  always #5 clk = ~clk;

  seven_segment_monitor #(.STABLE_CYCLES(4), .CNT_W(8)) u_a (
    .clk(clk), .reset_a(rsta),
    .seg_a(sa[6]), .seg_b(sa[5]), .seg_c(sa[4]), .seg_d(sa[3]),
    .seg_e(sa[2]), .seg_f(sa[1]), .seg_g(sa[0]),
    .rpt(ia), .overrun(ova), .err_cnt(eca)
  );

  seven_segment_monitor #(.STABLE_CYCLES(1), .CNT_W(8)) u_b (
    .clk(clk), .reset_a(rstb),
    .seg_a(sb[6]), .seg_b(sb[5]), .seg_c(sb[4]), .seg_d(sb[3]),
    .seg_e(sb[2]), .seg_f(sb[1]), .seg_g(sb[0]),
    .rpt(ib), .overrun(ovb), .err_cnt(ecb)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // accepted report = valid && ready going into the next rising edge
  always @(negedge clk) begin
    if (!rsta && ia.out_valid && ia.out_ready) begin
      if (qa.size() == 0) check("a_unexpected_report", qa.size(), 1);
      else begin
        logic [3:0] e;
        e = qa.pop_front();
        check("a_code", ia.code, e[2:0]);
        check("a_code_err", ia.code_err, e[3]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rstb && ib.out_valid && ib.out_ready) begin
      if (qb.size() == 0) check("b_unexpected_report", qb.size(), 1);
      else begin
        logic [3:0] e;
        e = qb.pop_front();
        check("b_code", ib.code, e[2:0]);
        check("b_code_err", ib.code_err, e[3]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rsta = 1'b1; rstb = 1'b1;
    sa = PAT_2;  sb = PAT_0;
    ia.out_ready = 1'b1;
    ib.out_ready = 1'b1;
    #3;
    check("rst_valid", ia.out_valid, 0);
    check("rst_code", ia.code, 0);
    check("rst_code_err", ia.code_err, 0);
    check("rst_overrun", ova, 0);
    check("rst_err_cnt", eca, 0);
    step(2);

    // stable 2 from reset: report 5 edges after first sample, one cycle wide
    qa.push_back({1'b0, CODE_2});
    rsta = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 4) check("lat_edge4_valid", ia.out_valid, 0);
      if (k == 5) check("lat_edge5_valid", ia.out_valid, 1);
    end
    @(posedge clk);
    @(negedge clk);
    check("single_cycle_valid", ia.out_valid, 0);
    @(posedge clk);
    #2;

    // short 1 run never qualifies; following 3 does
    sa = PAT_1;
    step(3);
    qa.push_back({1'b0, CODE_3});
    sa = PAT_3;
    step(12);
    check("short_run_q_empty", qa.size(), 0);

    // invalid pattern
    qa.push_back({1'b1, CODE_INV});
    sa = 7'b0000001;
    step(12);
    check("invalid_q_empty", qa.size(), 0);
    check("err_cnt", eca, ERR_EXP);

    // held report, second qualification dropped
    ia.out_ready = 1'b0;
    sa = PAT_0;
    step(6);
    check("hold_valid_early", ia.out_valid, 1);
    sa = PAT_E;
    step(6);
    check("hold_valid", ia.out_valid, 1);
    check("hold_code", ia.code, CODE_0);
    check("hold_code_err", ia.code_err, 0);
    check("overrun_set", ova, 1);
    qa.push_back({1'b0, CODE_0});
    ia.out_ready = 1'b1;
    step(8);
    check("after_accept_valid", ia.out_valid, 0);
    check("dropped_q_empty", qa.size(), 0);
    check("overrun_sticky", ova, 1);

    // reset in HOLD discards the pending report
    ia.out_ready = 1'b0;
    sa = PAT_3;
    step(7);
    check("pre_rst_valid", ia.out_valid, 1);
    check("pre_rst_code", ia.code, CODE_3);
    @(negedge clk);
    #1;
    rsta = 1'b1;
    #1;
    check("mid_rst_valid", ia.out_valid, 0);
    check("mid_rst_code", ia.code, 0);
    check("mid_rst_overrun", ova, 0);
    check("mid_rst_err_cnt", eca, 0);
    @(posedge clk);
    #2;
    qa.push_back({1'b0, CODE_3});
    ia.out_ready = 1'b1;
    rsta = 1'b0;
    step(10);
    check("post_rst_q_empty", qa.size(), 0);
    check("post_rst_valid", ia.out_valid, 0);

    // STABLE_CYCLES=1: toggle every cycle, one report per sample
    for (int i = 0; i < 8; i++)
      qb.push_back({1'b0, (i % 2 == 1) ? CODE_1 : CODE_0});
    rstb = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step(1);
      sb = (i % 2 == 1) ? PAT_1 : PAT_0;
    end
    step(12);
    check("toggle_q_empty", qb.size(), 0);
    check("toggle_overrun", ovb, 0);
    check("toggle_final_valid", ib.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_monitor.md
SEVEN_SEGMENT_MONITOR -- requirements
Module: seven_segment_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 1..255: consecutive identical samples needed to qualify a pattern.
REQ-002 SHALL have parameter CNT_W, default 8: stability counter width, at least clog2(STABLE_CYCLES+1).
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset_a  input  1  asynchronous active-high reset.
REQ-006 seg_a..seg_g  input  1 each  segment lines, active-high, synchronous to clk.
REQ-007 out_ready  input  1  consumer accepts the current report.
REQ-008 out_valid  output  1  report available.
REQ-009 code  output  3  decoded value.
REQ-010 code_err  output  1  reported pattern is not in the table.
REQ-011 overrun  output  1  sticky flag: a qualified pattern was dropped.
REQ-012 err_cnt  output  8  count of invalid reports; function set by SEG_ERR_CNT_EN.

Function
REQ-013 Register {a..g} into seg_q on every clk edge; all decisions use seg_q only.
REQ-014 Decode table ({a,b,c,d,e,f,g} -> code):
- 1111110 -> 000
- 0110000 -> 001
- 1101101 -> 010
- 1111001 -> 011
- 1001111 -> 100
REQ-015 Any other pattern, including all-zero, SHALL decode to code 111 with code_err=1.
REQ-016 Stability counter:
- Loads 1 when seg_q differs from its previous value.
- Otherwise increments, saturating at STABLE_CYCLES.
REQ-017 A pattern qualifies in the single cycle the counter reaches STABLE_CYCLES.
- Qualification is one-shot per stable run.
- It is suppressed if the pattern equals last_rep, except for the first qualification after reset.
REQ-018 On qualification, last_rep SHALL update to the qualified pattern, whether or not the report is captured.
REQ-019 FSM WAIT: a qualification captures code/code_err into the output registers, sets out_valid on the next edge and moves to HOLD.
REQ-020 Latency: out_valid rises STABLE_CYCLES+1 edges after the edge on which the new input is first sampled.
REQ-021 FSM HOLD: out_valid, code and code_err SHALL stay stable until out_valid&&out_ready at an edge, then return to WAIT with out_valid low on the following cycle.
REQ-022 A qualification in HOLD without acceptance in the same cycle SHALL be dropped and SHALL set overrun.
REQ-023 A qualification in the same cycle as acceptance SHALL be captured, with out_valid staying high and no overrun.
REQ-024 The input changing mid-count restarts the count; no partial report is ever produced.

Reset
REQ-025 reset_a high SHALL immediately force:
- out_valid=0, code=000, code_err=0, overrun=0, err_cnt=0
- seg_q=0, counter=0, FSM=WAIT
- last_rep cleared, first-after-reset marked pending
REQ-026 Reset during HOLD SHALL discard the pending report; it is never presented after reset.
REQ-027 Reset release is synchronous to clk; the first sample is taken on the first edge after release.

Configuration
REQ-028 With SEG_ERR_CNT_EN defined, err_cnt SHALL increment, saturating at 255, on each captured report with code_err=1.
REQ-029 Without SEG_ERR_CNT_EN, err_cnt SHALL be tied to 0 and its counter logic is not compiled.

Structure
REQ-030 Shared package seg_pkg SHALL hold:
- the five segment-pattern constants
- the code constants (CODE_0..CODE_3, CODE_E=100, CODE_INV=111)
- the FSM state typedef {WAIT, HOLD}
REQ-031 Combinational lookup SHALL be sub-module seg_pattern_decode (7-bit pattern in; code and code_err out); the FSM, counter and registers stay in the top level.

Verification (STABLE_CYCLES=4 unless noted)
REQ-032 Hold 1101101 with out_ready=1 -> out_valid for one cycle, 5 edges after first sample, code=010, code_err=0.
REQ-033 Hold 0110000 for 3 cycles, then 1111001 held, out_ready=1 -> only one report, code=011; no report for 001.
REQ-034 Hold 0000001 -> code=111, code_err=1; err_cnt=1 with SEG_ERR_CNT_EN, 0 without.
REQ-035 out_ready=0; present 1111110 then 1001111, each stable for 6 cycles -> out_valid holds code=000, overrun=1; after out_ready=1, out_valid drops and no 100 report follows.
REQ-036 Pulse reset_a mid-HOLD with code=011 -> out_valid=0 at once; after release, holding 1111001 produces a fresh report, code=011.
REQ-037 Set STABLE_CYCLES=1; toggle the input between 1111110 and 0110000 every cycle with out_ready=1 -> one report per change, alternating codes 000/001.
